// File: rtl/btclk_pkg.sv
// btclk_pkg -- shared constants, link role encoding and counter helpers for
// the multi-link Bluetooth clock (btclk_multilink / btclk_link).
//   US_PER_SLOT    : microseconds per 625 us slot
//   HALF_US        : microseconds per half slot (half tick fires at HALF_US-1)
//   WIN_FORCE      : windows wider than this hold uncer_win permanently high
//   WIN_CLOSE_BASE : window closes at this link us + window size
package btclk_pkg;

    localparam int US_PER_SLOT    = 625;
    localparam int HALF_US        = 312;
    localparam int WIN_FORCE      = 312;
    localparam int WIN_CLOSE_BASE = 68;

    typedef enum logic {
        ROLE_SLAVE  = 1'b0,
        ROLE_MASTER = 1'b1
    } link_role_e;

    // Microsecond counter advance, 0..624 wrapping.
    function automatic logic [9:0] us_next(input logic [9:0] us);
        return (us == 10'(US_PER_SLOT - 1)) ? 10'd0 : us + 10'd1;
    endfunction

    // True at the two microseconds where a 312.5 us clock tick is due.
    function automatic logic slot_edge(input logic [9:0] us);
        return (us == 10'(HALF_US - 1)) || (us == 10'(US_PER_SLOT - 1));
    endfunction

endpackage

// File: rtl/btclk_link.sv
// btclk_link -- one link clock: link microsecond counter, 28-bit raw clock,
// offset, uncertainty window and slot pulses.
// Optional feature macro: BTCLK_FHS_LOAD_EN (adds fhs_load_p / fhs_clk).
// Ports:
//   clk_6M, rst          : clock, synchronous active-high reset
//   p_1us                : 1 us strobe from the shared prescaler (already
//                          forced low during reset)
//   cfg_we, cfg_master,
//   cfg_win, cfg_offset  : config write for this link
//   sync_p               : correlator sync (slave only)
//   fhs_load_p, fhs_clk  : FHS clock load (BTCLK_FHS_LOAD_EN only)
//   link_clk             : raw + {offset,2'b00}
//   tslot_p, half_tslot_p, tx_endp, rx_endp, uncer_win : link outputs
module btclk_link
    import btclk_pkg::*;
#(
    parameter int SYNC_US = 68,
    parameter int WIN_W   = 9
) (
    input  logic             clk_6M,
    input  logic             rst,
    input  logic             p_1us,
    input  logic             cfg_we,
    input  logic             cfg_master,
    input  logic [WIN_W-1:0] cfg_win,
    input  logic [25:0]      cfg_offset,
    input  logic             sync_p,
`ifdef BTCLK_FHS_LOAD_EN
    input  logic             fhs_load_p,
    input  logic [25:0]      fhs_clk,
`endif
    output logic [27:0]      link_clk,
    output logic             tslot_p,
    output logic             half_tslot_p,
    output logic             tx_endp,
    output logic             rx_endp,
    output logic             uncer_win
);

    link_role_e       role;
    logic [WIN_W-1:0] win;
    logic [25:0]      offset;
    logic [9:0]       us;
    logic [27:0]      raw;
    logic [27:0]      raw_nxt;
    logic             win_q;
    logic             sync_eff;
    logic             adv;
    logic             pre_rx;
    logic [31:0]      win_open_us;
    logic [31:0]      win_close_us;

    // A sync on a slave overrides this cycle's advance entirely, so neither
    // the pulses nor the raw tick fire in that cycle.
    assign sync_eff     = sync_p && (role == ROLE_SLAVE);
    assign adv          = p_1us && !sync_eff;
    assign half_tslot_p = adv && (us == 10'(HALF_US - 1));
    assign tslot_p      = adv && (us == 10'(US_PER_SLOT - 1));
    assign raw_nxt      = (half_tslot_p || tslot_p) ? raw + 28'd1 : raw;
    assign link_clk     = raw + {offset, 2'b00};

    // Pre-RX half: master transmits when link_clk[1]==0, slave when ==1.
    // The slot that ends in the pre-RX half is a TX slot for either role.
    assign pre_rx  = (role == ROLE_MASTER) ? !link_clk[1] : link_clk[1];
    assign tx_endp = tslot_p && pre_rx;
    assign rx_endp = tslot_p && !pre_rx;

    assign win_open_us  = 32'(US_PER_SLOT) - 32'(win);
    assign win_close_us = 32'(WIN_CLOSE_BASE) + 32'(win);

    // Zero width can never open (open point 625 is unreachable); the extra
    // gate also drops a window left open by a reconfiguration to zero.
    assign uncer_win = (32'(win) > 32'(WIN_FORCE)) || (win_q && (win != '0));

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            role   <= ROLE_SLAVE;
            win    <= '0;
            offset <= '0;
            us     <= '0;
            raw    <= '0;
            win_q  <= 1'b0;
        end else begin
            raw <= raw_nxt;

            if (sync_eff)
                us <= 10'(SYNC_US);
            else if (p_1us)
                us <= us_next(us);

            if (adv) begin
                if (pre_rx && (32'(us) == win_open_us))
                    win_q <= 1'b1;
                else if (!pre_rx && (32'(us) == win_close_us))
                    win_q <= 1'b0;
            end

            if (cfg_we) begin
                role   <= link_role_e'(cfg_master);
                win    <= cfg_win;
                offset <= cfg_offset;
            end
`ifdef BTCLK_FHS_LOAD_EN
            // Offset chosen so link_clk[27:2] equals fhs_clk next cycle;
            // overrides a same-cycle config offset (role/window still written).
            if (fhs_load_p)
                offset <= fhs_clk - raw_nxt[27:2];
`endif
        end
    end

endmodule

// File: rtl/btclk_multilink.sv
// btclk_multilink -- native Bluetooth clock plus NUM_LINKS independent link
// clocks sharing one 6 MHz prescaler.
// Optional feature macro: BTCLK_FHS_LOAD_EN (adds fhs_load_p / fhs_clk).
// Ports:
//   clk_6M, rst            : 6 MHz clock, synchronous active-high reset
//   cfg_we, cfg_idx        : config write strobe and target link
//   cfg_master, cfg_win,
//   cfg_offset             : role, window size (us), offset[27:2]
//   sync_p[NUM_LINKS]      : per-link correlator sync pulse
//   fhs_load_p, fhs_clk    : per-link FHS clock load (BTCLK_FHS_LOAD_EN only)
//   p_1us                  : 1 us strobe
//   clkn                   : native clock, never resynced
//   link_clk               : link i clock in bits [28i+27:28i]
//   tslot_p, half_tslot_p,
//   tx_endp, rx_endp,
//   uncer_win              : per-link outputs, bit i for link i
module btclk_multilink
    import btclk_pkg::*;
#(
    parameter int NUM_LINKS = 4,
    parameter int SYNC_US   = 68,
    parameter int WIN_W     = 9,
    localparam int IDX_W    = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1
) (
    input  logic                    clk_6M,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [IDX_W-1:0]        cfg_idx,
    input  logic                    cfg_master,
    input  logic [WIN_W-1:0]        cfg_win,
    input  logic [25:0]             cfg_offset,
    input  logic [NUM_LINKS-1:0]    sync_p,
`ifdef BTCLK_FHS_LOAD_EN
    input  logic [NUM_LINKS-1:0]    fhs_load_p,
    input  logic [25:0]             fhs_clk,
`endif
    output logic                    p_1us,
    output logic [27:0]             clkn,
    output logic [NUM_LINKS*28-1:0] link_clk,
    output logic [NUM_LINKS-1:0]    tslot_p,
    output logic [NUM_LINKS-1:0]    half_tslot_p,
    output logic [NUM_LINKS-1:0]    tx_endp,
    output logic [NUM_LINKS-1:0]    rx_endp,
    output logic [NUM_LINKS-1:0]    uncer_win
);

    logic [2:0] presc;
    logic [9:0] nat_us;

    // Forcing the strobe low in reset also silences every link pulse, since
    // all of them are qualified by it.
    assign p_1us = (presc == 3'd5) && !rst;

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            presc  <= '0;
            nat_us <= '0;
            clkn   <= '0;
        end else begin
            presc <= (presc == 3'd5) ? 3'd0 : presc + 3'd1;
            if (p_1us) begin
                nat_us <= us_next(nat_us);
                if (slot_edge(nat_us))
                    clkn <= clkn + 28'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_LINKS; i++) begin : g_link
        logic link_we;

        // Out-of-range indices match no instance and are dropped.
        assign link_we = cfg_we && (cfg_idx == IDX_W'(i));

        btclk_link #(
            .SYNC_US (SYNC_US),
            .WIN_W   (WIN_W)
        ) u_link (
            .clk_6M       (clk_6M),
            .rst          (rst),
            .p_1us        (p_1us),
            .cfg_we       (link_we),
            .cfg_master   (cfg_master),
            .cfg_win      (cfg_win),
            .cfg_offset   (cfg_offset),
            .sync_p       (sync_p[i]),
`ifdef BTCLK_FHS_LOAD_EN
            .fhs_load_p   (fhs_load_p[i]),
            .fhs_clk      (fhs_clk),
`endif
            .link_clk     (link_clk[28*i +: 28]),
            .tslot_p      (tslot_p[i]),
            .half_tslot_p (half_tslot_p[i]),
            .tx_endp      (tx_endp[i]),
            .rx_endp      (rx_endp[i]),
            .uncer_win    (uncer_win[i])
        );
    end

endmodule

// File: tb/tb_btclk_multilink.sv
// tb_btclk_multilink -- directed, table-driven bench for btclk_multilink.
// Define BTCLK_FHS_LOAD_EN for both bench and RTL to cover the FHS load.
module tb_btclk_multilink;

    logic          clk_6M = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [1:0]    cfg_idx;
    logic          cfg_master;
    logic [8:0]    cfg_win;
    logic [25:0]   cfg_offset;
    logic [3:0]    sync_p;
`ifdef BTCLK_FHS_LOAD_EN
    logic [3:0]    fhs_load_p;
    logic [25:0]   fhs_clk;
`endif
    logic          p_1us;
    logic [27:0]   clkn;
    logic [111:0]  link_clk;
    logic [3:0]    tslot_p, half_tslot_p, tx_endp, rx_endp, uncer_win;

    int checks = 0;
    int errors = 0;
    int np     = 0;     // p_1us strobes completed since reset
    bit track  = 0;
    int ts_q[$];        // indices of tslot_p[0] during the table run

    always #5 clk_6M = ~clk_6M;

    btclk_multilink #(.NUM_LINKS(4), .SYNC_US(68), .WIN_W(9)) dut (
        .clk_6M       (clk_6M),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_master   (cfg_master),
        .cfg_win      (cfg_win),
        .cfg_offset   (cfg_offset),
        .sync_p       (sync_p),
`ifdef BTCLK_FHS_LOAD_EN
        .fhs_load_p   (fhs_load_p),
        .fhs_clk      (fhs_clk),
`endif
        .p_1us        (p_1us),
        .clkn         (clkn),
        .link_clk     (link_clk),
        .tslot_p      (tslot_p),
        .half_tslot_p (half_tslot_p),
        .tx_endp      (tx_endp),
        .rx_endp      (rx_endp),
        .uncer_win    (uncer_win)
    );

    typedef struct {
        int          n;
        logic [27:0] clkn;
        logic [3:0]  tslot, half, tx, rx, uncer;
        logic [27:0] lc0, lc1;
    } vec_t;

    vec_t tbl[15];

    function automatic logic [27:0] lc(input int i);
        return link_clk[28*i +: 28];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        if (p_1us) begin
            if (track && tslot_p[0] && np <= 1250) ts_q.push_back(np);
            np++;
        end
        @(posedge clk_6M);
        #1;
    endtask

    // Advance to the cycle in which the strobe with index n is high.
    task automatic goto_us(input int n);
        int guard;
        guard = 0;
        while (!(p_1us && np == n) && guard < 20000) begin
            cyc();
            guard++;
        end
        chk($sformatf("goto_%0d_timeout", n), 32'(guard < 20000), 32'd1);
    endtask

    task automatic cfg(input int idx, input logic m, input logic [8:0] w, input logic [25:0] o);
        cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_master = m; cfg_win = w; cfg_offset = o;
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; cfg_we = 1'b0; sync_p = '0;
        repeat (3) cyc();
        chk({tag, "_rst_p1us"}, 32'(p_1us), 32'd0);
        chk({tag, "_rst_clkn"}, 32'(clkn), 32'd0);
        chk({tag, "_rst_tslot"}, 32'(tslot_p | half_tslot_p | tx_endp | rx_endp), 32'd0);
        chk({tag, "_rst_uncer"}, 32'(uncer_win), 32'd0);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_rst_lc%0d", tag, i), 32'(lc(i)), 32'd0);
        rst = 1'b0;
        np  = 0;
        chk({tag, "_post_p1us"}, 32'(p_1us), 32'd0);
        chk({tag, "_post_pulses"}, 32'(tslot_p | half_tslot_p | tx_endp | rx_endp), 32'd0);
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_master = 1'b0;
        cfg_win = '0; cfg_offset = '0; sync_p = '0;
`ifdef BTCLK_FHS_LOAD_EN
        fhs_load_p = '0; fhs_clk = '0;
`endif
        //        n     clkn  tslot  half   tx     rx     uncer  lc0 lc1
        tbl[0]  = '{0,    0,  4'h0,  4'h0,  4'h0,  4'h0,  4'h8,  0, 12};
        tbl[1]  = '{311,  0,  4'h0,  4'hF,  4'h0,  4'h0,  4'h8,  0, 12};
        tbl[2]  = '{312,  1,  4'h0,  4'h0,  4'h0,  4'h0,  4'h8,  1, 13};
        tbl[3]  = '{615,  1,  4'h0,  4'h0,  4'h0,  4'h0,  4'h8,  1, 13};
        tbl[4]  = '{616,  1,  4'h0,  4'h0,  4'h0,  4'h0,  4'hC,  1, 13};
        tbl[5]  = '{624,  1,  4'hF,  4'h0,  4'h4,  4'hB,  4'hC,  1, 13};
        tbl[6]  = '{625,  2,  4'h0,  4'h0,  4'h0,  4'h0,  4'hC,  2, 14};
        tbl[7]  = '{703,  2,  4'h0,  4'h0,  4'h0,  4'h0,  4'hC,  2, 14};
        tbl[8]  = '{704,  2,  4'h0,  4'h0,  4'h0,  4'h0,  4'h8,  2, 14};
        tbl[9]  = '{1240, 3,  4'h0,  4'h0,  4'h0,  4'h0,  4'h8,  3, 15};
        tbl[10] = '{1241, 3,  4'h0,  4'h0,  4'h0,  4'h0,  4'h8,  3, 15};
        tbl[11] = '{1249, 3,  4'hF,  4'h0,  4'hB,  4'h4,  4'h8,  3, 15};
        tbl[12] = '{1250, 4,  4'h0,  4'h0,  4'h0,  4'h0,  4'h8,  4, 16};
        tbl[13] = '{1865, 5,  4'h0,  4'h0,  4'h0,  4'h0,  4'h8,  5, 17};
        tbl[14] = '{1866, 5,  4'h0,  4'h0,  4'h0,  4'h0,  4'hC,  5, 17};

        // Link 0 slave/win 0, link 1 slave offset 3, link 2 master win 10,
        // link 3 slave win 400 (forced open).
        do_reset("init");
        cfg(0, 1'b0, 9'd0,   26'd0);
        cfg(1, 1'b0, 9'd0,   26'd3);
        cfg(2, 1'b1, 9'd10,  26'd0);
        cfg(3, 1'b0, 9'd400, 26'd0);
        track = 1;
        for (int k = 0; k < 15; k++) begin
            goto_us(tbl[k].n);
            chk($sformatf("n%0d_clkn", tbl[k].n),  32'(clkn),         32'(tbl[k].clkn));
            chk($sformatf("n%0d_tslot", tbl[k].n), 32'(tslot_p),      32'(tbl[k].tslot));
            chk($sformatf("n%0d_half", tbl[k].n),  32'(half_tslot_p), 32'(tbl[k].half));
            chk($sformatf("n%0d_tx", tbl[k].n),    32'(tx_endp),      32'(tbl[k].tx));
            chk($sformatf("n%0d_rx", tbl[k].n),    32'(rx_endp),      32'(tbl[k].rx));
            chk($sformatf("n%0d_uncer", tbl[k].n), 32'(uncer_win),    32'(tbl[k].uncer));
            chk($sformatf("n%0d_lc0", tbl[k].n),   32'(lc(0)),        32'(tbl[k].lc0));
            chk($sformatf("n%0d_lc1", tbl[k].n),   32'(lc(1)),        32'(tbl[k].lc1));
        end
        track = 0;
        chk("tslot0_count", 32'(ts_q.size()), 32'd2);
        if (ts_q.size() == 2) begin
            chk("tslot0_first", 32'(ts_q[0]), 32'd624);
            chk("tslot0_spacing", 32'(ts_q[1] - ts_q[0]), 32'd625);
        end

        // Reset landing on a slot-end strobe: pulses vanish immediately.
        goto_us(2499);
        chk("pre_mid_rst_tslot", 32'(tslot_p), 32'hF);
        rst = 1'b1;
        #1;
        chk("mid_rst_tslot", 32'(tslot_p), 32'd0);
        chk("mid_rst_p1us", 32'(p_1us), 32'd0);
        chk("mid_rst_tx_rx", 32'(tx_endp | rx_endp), 32'd0);
        do_reset("mid");

        // Slave sync at native us 200 (link 1), master link 2 ignores it;
        // same-cycle config write to link 1 also lands.
        cfg(2, 1'b1, 9'd0, 26'd0);
        goto_us(200);
        sync_p = 4'b0110;
        cfg(1, 1'b0, 9'd0, 26'd1);
        sync_p = '0;
        goto_us(444);
        chk("sync_half1", 32'(half_tslot_p), 32'h2);
        goto_us(624);
        chk("sync_tslot_native", 32'(tslot_p), 32'hD);
        goto_us(700);
        chk("sync_lc1", 32'(lc(1)), 32'd5);
        chk("sync_lc0", 32'(lc(0)), 32'd2);
        goto_us(757);
        chk("sync_tslot1", 32'(tslot_p), 32'h2);

`ifdef BTCLK_FHS_LOAD_EN
        do_reset("fhs");
        fhs_load_p = 4'b1000;
        fhs_clk    = 26'h3FFFFFF;
        cfg(3, 1'b0, 9'd0, 26'd7);
        fhs_load_p = '0;
        chk("fhs_lc3_load", 32'(lc(3)), 32'hFFFFFFC);
        chk("fhs_lc2_untouched", 32'(lc(2)), 32'd0);
        goto_us(1249);
        chk("fhs_lc3_pre_wrap", 32'(lc(3)), 32'hFFFFFFF);
        goto_us(1250);
        chk("fhs_lc3_wrap", 32'(lc(3)), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btclk_multilink.md
BTCLK_MULTILINK -- requirements
Module: btclk_multilink

Interface
REQ-001 SHALL have parameter NUM_LINKS, default 4, number of independent link clocks (1..8).
REQ-002 SHALL have parameter SYNC_US, default 68, link microsecond count loaded on sync.
REQ-003 SHALL have parameter WIN_W, default 9, uncertainty-window size width.
REQ-004 SHALL have port clk_6M  in  1  6 MHz clock, single clock domain.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port cfg_we  in  1  per-link config write strobe.
REQ-007 SHALL have port cfg_idx  in  $clog2(NUM_LINKS)  link selected by cfg_we.
REQ-008 SHALL have ports cfg_master (in, 1, role), cfg_win (in, WIN_W, window size in us) and cfg_offset (in, 26, offset[27:2]).
REQ-009 SHALL have port sync_p  in  NUM_LINKS  per-link correlator sync pulse.
REQ-010 SHALL have ports fhs_load_p (in, NUM_LINKS) and fhs_clk (in, 26, FHS CLK[27:2]), only with BTCLK_FHS_LOAD_EN.
REQ-011 SHALL have outputs p_1us (1) and clkn (28, native clock, never resynced).
REQ-012 SHALL have output link_clk  NUM_LINKS*28  link i clock in bits [28i+27:28i].
REQ-013 SHALL have outputs tslot_p, half_tslot_p, tx_endp, rx_endp and uncer_win, each NUM_LINKS wide, bit i for link i.

Function
REQ-014 SHALL run a 6-state prescaler 0..5; p_1us=1 while it is 5.
REQ-015 SHALL keep a native us counter 0..624 and a link us counter per link, each advancing on p_1us and wrapping 624->0.
REQ-016 SHALL pulse half_tslot_p[i] on p_1us with link us==311, and tslot_p[i] on p_1us with link us==624.
REQ-017 SHALL increment raw link counter raw[i] (28-bit, wrapping) on each half_tslot_p[i] and tslot_p[i]; clkn increments likewise from the native counter.
REQ-018 SHALL output link_clk[i] = raw[i] + {offset[i],2'b00}, modulo 2^28.
REQ-019 SHALL drive, for a master link, tx_endp=!link_clk[1]&tslot_p and rx_endp=link_clk[1]&tslot_p; a slave link uses the inverted link_clk[1] terms.
REQ-020 SHALL load link us counter with SYNC_US on sync_p[i] for slave links; master links ignore sync_p.
REQ-021 SHALL give sync_p priority over the p_1us advance; raw[i] does not tick that cycle.
REQ-022 SHALL set uncer_win[i] on p_1us at link us==625-win while in the pre-RX half (master !link_clk[1], slave link_clk[1]), and clear it at link us==68+win in the opposite half.
REQ-023 SHALL hold uncer_win[i]=1 while win>312; win==0 never opens the window.
REQ-024 SHALL write cfg_master, cfg_win and cfg_offset of link cfg_idx on cfg_we, effective next cycle; cfg_idx>=NUM_LINKS is ignored.
REQ-025 SHALL apply a cfg_we and a sync_p to the same link in the same cycle both, independently.

Reset
REQ-026 SHALL clear, on rst, the prescaler, all us counters, raw[i], clkn, offsets and windows to 0, and set every link to slave with win=0.
REQ-027 SHALL hold every output pulse at 0 during rst and in the first cycle after it; rst mid-slot abandons the slot.

Configuration
REQ-028 SHALL, with BTCLK_FHS_LOAD_EN defined, set offset[i] <= fhs_clk - next_raw[i][27:2] on fhs_load_p[i], so link_clk[i][27:2]==fhs_clk next cycle; fhs_load_p wins over a same-cycle cfg_we to that link.
REQ-029 SHALL, without BTCLK_FHS_LOAD_EN, omit fhs_load_p and fhs_clk and change offsets only via cfg_we.

Structure
REQ-030 SHALL put US_PER_SLOT=625, HALF_US=312, WIN_FORCE=312, WIN_CLOSE_BASE=68 and the link-role encoding in package btclk_pkg.
REQ-031 SHALL instantiate sub-module btclk_link once per link (us counter, raw, offset, window, pulses); the top holds the prescaler, native counter and config decode.

Verification
REQ-032 SHALL check: after rst, 1250 p_1us give clkn==4 and tslot_p[0] twice, 625 us apart.
REQ-033 SHALL check: link 1 slave, sync_p[1] at native us 200 -> link 1 us==68 next cycle, tslot_p[1] 557 p_1us later.
REQ-034 SHALL check: link 2 master, cfg_win=10 -> uncer_win[2] rises at us 615 (link_clk[1]=0), falls at us 78.
REQ-035 SHALL check: cfg_win=400 -> uncer_win constantly 1; cfg_win=0 -> constantly 0.
REQ-036 SHALL check: with BTCLK_FHS_LOAD_EN, fhs_load_p[3] with fhs_clk=26'h3FFFFFF -> link_clk[3][27:2]==26'h3FFFFFF, wrapping to 0 four ticks later.
